// File: rtl/id_ex_stage.sv
// ID/EX boundary: decodes a MIPS word into ALU operands/controls behind a two-entry skid buffer.
// Optional writeback bypass at capture is enabled by defining OPERAND_BYPASS_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic        flush,
  input  logic        ex_wr,
  input  logic [4:0]  ex_dest,
  input  logic [31:0] ex_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] value1,
  output logic [31:0] value2,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [4:0]  out_dest,
  output logic        out_illegal,
  output logic [15:0] issued_count
);

  typedef struct packed {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dst;
    logic        ill;
  } entry_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;

  entry_t      dec, main_q, skid_q;
  logic        main_vld, skid_vld;
  logic        accept, deliver;
  logic [5:0]  d_op, d_fn;
  logic [4:0]  d_rs, d_rt, d_rd;
  logic [15:0] d_imm;
  logic [31:0] rs_val, rt_val;
  logic        fn_ok;

  assign d_op  = in_instr[31:26];
  assign d_fn  = in_instr[5:0];
  assign d_rs  = in_instr[25:21];
  assign d_rt  = in_instr[20:16];
  assign d_rd  = in_instr[15:11];
  assign d_imm = in_instr[15:0];

`ifdef OPERAND_BYPASS_EN
  // rt is only a source operand for R-type; for I-type it names the destination
  always_comb begin
    rs_val = in_rs_data;
    rt_val = in_rt_data;
    if (ex_wr && (ex_dest != 5'd0) && (ex_dest == d_rs))
      rs_val = ex_result;
    if (ex_wr && (ex_dest != 5'd0) && (ex_dest == d_rt) && (d_op == OP_RTYPE))
      rt_val = ex_result;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{ex_wr, ex_dest, ex_result};
  assign rs_val = in_rs_data;
  assign rt_val = in_rt_data;
`endif

  always_comb begin
    fn_ok = 1'b0;
    case (d_fn)
      6'd32, 6'd33, 6'd36, 6'd37, 6'd24: fn_ok = 1'b1;
      default:                           fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec    = '0;
    dec.op = d_op;
    case (d_op)
      OP_RTYPE: begin
        dec.fn = d_fn;
        if (fn_ok) begin
          dec.v1  = rs_val;
          dec.v2  = rt_val;
          dec.dst = d_rd;
        end else begin
          dec.ill = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU: begin
        dec.v1  = rs_val;
        dec.v2  = {{16{d_imm[15]}}, d_imm};
        dec.dst = d_rt;
      end
      OP_ANDI, OP_ORI: begin
        dec.v1  = rs_val;
        dec.v2  = {16'd0, d_imm};
        dec.dst = d_rt;
      end
      default: dec.ill = 1'b1;
    endcase
  end

  // in_ready depends only on registered state, so out_ready never reaches it combinationally
  assign in_ready = ~skid_vld;
  assign accept   = in_valid & in_ready;
  assign deliver  = main_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || deliver) begin
      // skid full implies in_ready=0, so no accept competes with the skid refill
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       issued_count <= 16'd0;
    else if (deliver) issued_count <= issued_count + 16'd1;
  end

  assign out_valid   = main_vld;
  assign value1      = main_q.v1;
  assign value2      = main_q.v2;
  assign opcode      = main_q.op;
  assign func        = main_q.fn;
  assign out_dest    = main_q.dst;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a queue-based model of the two-entry buffer.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0, in_rs_data = '0, in_rt_data = '0;
  logic        flush = 1'b0;
  logic        ex_wr = 1'b0;
  logic [4:0]  ex_dest = '0;
  logic [31:0] ex_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] value1, value2;
  logic [5:0]  opcode, func;
  logic [4:0]  out_dest;
  logic        out_illegal;
  logic [15:0] issued_count;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .flush(flush), .ex_wr(ex_wr), .ex_dest(ex_dest), .ex_result(ex_result),
    .out_valid(out_valid), .out_ready(out_ready), .value1(value1), .value2(value2),
    .opcode(opcode), .func(func), .out_dest(out_dest), .out_illegal(out_illegal),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v1, v2;
    logic [5:0]  op, fn;
    logic [4:0]  dst;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    logic [31:0] a, b;
    a = rsd; b = rtd;
`ifdef OPERAND_BYPASS_EN
    if (ex_wr && ex_dest != 0 && ex_dest == ins[25:21]) a = ex_result;
    if (ex_wr && ex_dest != 0 && ex_dest == ins[20:16] && ins[31:26] == 0) b = ex_result;
`endif
    e.op = ins[31:26]; e.fn = 0; e.ill = 0; e.v1 = 0; e.v2 = 0; e.dst = 0;
    if (e.op == 0) begin
      e.fn = ins[5:0];
      if (e.fn inside {6'd32, 6'd33, 6'd36, 6'd37, 6'd24}) begin
        e.v1 = a; e.v2 = b; e.dst = ins[15:11];
      end else e.ill = 1;
    end else if (e.op == 8 || e.op == 9) begin
      e.v1 = a; e.v2 = 32'(signed'(ins[15:0])); e.dst = ins[20:16];
    end else if (e.op == 12 || e.op == 13) begin
      e.v1 = a; e.v2 = {16'd0, ins[15:0]}; e.dst = ins[20:16];
    end else e.ill = 1;
    return e;
  endfunction

  // Called at a falling edge: applies inputs, advances the model over the coming rising edge, returns at the next falling edge.
  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                       input bit fl, input bit ordy);
    bit acc, dlv;
    in_valid = iv; in_instr = ins; in_rs_data = rsd; in_rt_data = rtd; flush = fl; out_ready = ordy;
    acc = iv && (exp_q.size() < 2);
    dlv = ordy && (exp_q.size() > 0);
    if (dlv) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    if (fl) exp_q.delete();
    else begin
      if (dlv) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model_decode(ins, rsd, rtd));
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if ({value1, value2, opcode, func, out_dest, out_illegal} !== '0) begin errors++;
      $display("FAIL reset_fields got v1=%h v2=%h op=%0d fn=%0d dst=%0d ill=%0b want all 0", value1, value2, opcode, func, out_dest, out_illegal); end
    checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", issued_count); end
    rst_n = 1'b1; exp_q.delete(); exp_cnt = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%0b vld=%0b want 1/0", in_ready, out_valid); end
    // reset in the middle of a full buffer
    drive(1, mk_r(1, 2, 3, 32), 32'd10, 32'd20, 0, 0);
    drive(1, mk_r(4, 5, 6, 33), 32'd30, 32'd40, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || issued_count !== 16'd0) begin errors++;
      $display("FAIL midreset got vld=%0b rdy=%0b cnt=%0d want 0/1/0", out_valid, in_ready, issued_count); end
    @(negedge clk); rst_n = 1'b1; exp_q.delete(); exp_cnt = 0;
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || issued_count !== 16'd0) begin errors++;
      $display("FAIL after_midreset got vld=%0b cnt=%0d want 0/0", out_valid, issued_count); end
  endtask

  task automatic test_rtype;
    drive(1, mk_r(1, 2, 9, 32), 32'd2, 32'd3, 0, 1);
    checks++; if ({out_valid, value1, value2, opcode, func, out_dest, out_illegal} !== {1'b1, 32'd2, 32'd3, 6'd0, 6'd32, 5'd9, 1'b0}) begin errors++;
      $display("FAIL rtype_add got vld=%0b v1=%0d v2=%0d op=%0d fn=%0d dst=%0d want 1/2/3/0/32/9", out_valid, value1, value2, opcode, func, out_dest); end
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || issued_count !== 16'(exp_cnt)) begin errors++;
      $display("FAIL rtype_drain got vld=%0b cnt=%0d want 0/%0d", out_valid, issued_count, exp_cnt); end
  endtask

  task automatic test_imm;
    drive(1, mk_i(8, 1, 7, 16'hFFFD), 32'd2, 32'd99, 0, 1);
    checks++; if ({value1, value2, opcode, func, out_dest, out_illegal} !== {32'd2, 32'hFFFFFFFD, 6'd8, 6'd0, 5'd7, 1'b0}) begin errors++;
      $display("FAIL addi got v1=%h v2=%h op=%0d fn=%0d dst=%0d want 2/fffffffd/8/0/7", value1, value2, opcode, func, out_dest); end
    drive(1, mk_i(12, 1, 4, 16'hFFFD), 32'd2, 32'd99, 0, 1);
    checks++; if ({value2, opcode, func, out_dest} !== {32'h0000FFFD, 6'd12, 6'd0, 5'd4}) begin errors++;
      $display("FAIL andi got v2=%h op=%0d fn=%0d dst=%0d want 0000fffd/12/0/4", value2, opcode, func, out_dest); end
    drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_illegal;
    drive(1, {6'd2, 26'h3ABCDEF}, 32'd5, 32'd6, 0, 1);
    checks++; if ({out_valid, out_illegal, value1, value2, out_dest} !== {1'b1, 1'b1, 64'd0, 5'd0}) begin errors++;
      $display("FAIL illegal_op got vld=%0b ill=%0b v1=%h v2=%h dst=%0d want 1/1/0/0/0", out_valid, out_illegal, value1, value2, out_dest); end
    drive(1, mk_r(1, 2, 3, 42), 32'd5, 32'd6, 0, 1);
    checks++; if ({out_illegal, value1, value2, out_dest} !== {1'b1, 64'd0, 5'd0}) begin errors++;
      $display("FAIL illegal_fn got ill=%0b v1=%h v2=%h dst=%0d want 1/0/0/0", out_illegal, value1, value2, out_dest); end
    drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_stall;
    int base;
    base = exp_cnt;
    drive(1, mk_r(1, 2, 11, 33), 32'd100, 32'd200, 0, 0);
    drive(1, mk_r(3, 4, 12, 36), 32'd300, 32'd400, 0, 0);
    checks++; if ({out_valid, in_ready, value1, value2, out_dest} !== {1'b1, 1'b0, 32'd100, 32'd200, 5'd11}) begin errors++;
      $display("FAIL stall_hold got vld=%0b rdy=%0b v1=%0d v2=%0d dst=%0d want 1/0/100/200/11", out_valid, in_ready, value1, value2, out_dest); end
    drive(1, mk_r(5, 6, 13, 37), 32'd1, 32'd1, 0, 0);
    checks++; if ({in_ready, value1, out_dest} !== {1'b0, 32'd100, 5'd11}) begin errors++;
      $display("FAIL stall_full got rdy=%0b v1=%0d dst=%0d want 0/100/11", in_ready, value1, out_dest); end
    drive(0, 0, 0, 0, 0, 1);
    checks++; if ({out_valid, value1, value2, out_dest, func} !== {1'b1, 32'd300, 32'd400, 5'd12, 6'd36}) begin errors++;
      $display("FAIL stall_second got vld=%0b v1=%0d v2=%0d dst=%0d fn=%0d want 1/300/400/12/36", out_valid, value1, value2, out_dest, func); end
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || issued_count !== 16'(base + 2)) begin errors++;
      $display("FAIL stall_count got vld=%0b cnt=%0d want 0/%0d", out_valid, issued_count, base + 2); end
  endtask

  task automatic test_flush;
    int base;
    drive(1, mk_r(1, 2, 3, 32), 32'd1, 32'd2, 0, 0);
    drive(1, mk_r(1, 2, 4, 32), 32'd1, 32'd2, 0, 0);
    base = exp_cnt;
    drive(1, mk_r(1, 2, 5, 32), 32'd1, 32'd2, 1, 0);
    checks++; if ({out_valid, in_ready} !== 2'b01 || issued_count !== 16'(base)) begin errors++;
      $display("FAIL flush got vld=%0b rdy=%0b cnt=%0d want 0/1/%0d", out_valid, in_ready, issued_count, base); end
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || issued_count !== 16'(base)) begin errors++;
      $display("FAIL flush_dropped got vld=%0b cnt=%0d want 0/%0d", out_valid, issued_count, base); end
    // a delivery in the flush cycle still counts
    drive(1, mk_r(1, 2, 6, 32), 32'd1, 32'd2, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (out_valid !== 1'b0 || issued_count !== 16'(base + 1)) begin errors++;
      $display("FAIL flush_deliver got vld=%0b cnt=%0d want 0/%0d", out_valid, issued_count, base + 1); end
  endtask

  task automatic test_bypass;
    logic [31:0] want;
`ifdef OPERAND_BYPASS_EN
    want = 32'd7;
`else
    want = 32'd2;
`endif
    ex_wr = 1; ex_dest = 5; ex_result = 32'd7;
    drive(1, mk_r(5, 6, 8, 32), 32'd2, 32'd3, 0, 1);
    checks++; if (value1 !== want || value2 !== 32'd3) begin errors++;
      $display("FAIL bypass_rs got v1=%0d v2=%0d want %0d/3", value1, value2, want); end
    ex_dest = 0;
    drive(1, mk_r(0, 6, 8, 32), 32'd2, 32'd3, 0, 1);
    checks++; if (value1 !== 32'd2) begin errors++; $display("FAIL bypass_zero got v1=%0d want 2", value1); end
    ex_wr = 0;
    drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random;
    logic [31:0] ins;
    int ops[8] = '{0, 0, 8, 9, 12, 13, 2, 35};
    int fns[6] = '{32, 33, 36, 37, 24, 42};
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      ins[31:26] = 6'(ops[$urandom_range(0, 7)]);
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      if (ins[31:26] == 0) ins[5:0] = 6'(fns[$urandom_range(0, 5)]);
      ex_wr = 1'($urandom); ex_dest = 5'($urandom_range(0, 7)); ex_result = $urandom;
      drive(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom, $urandom_range(0, 40) == 0, 1'($urandom_range(0, 2) != 0));
      checks++; if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2) || issued_count !== 16'(exp_cnt)) begin errors++;
        $display("FAIL rand_ctrl[%0d] got vld=%0b rdy=%0b cnt=%0d want %0b/%0b/%0d", i, out_valid, in_ready, issued_count, exp_q.size() > 0, exp_q.size() < 2, exp_cnt); end
      if (exp_q.size() > 0) begin
        checks++;
        if ({value1, value2, out_dest, out_illegal} !== {exp_q[0].v1, exp_q[0].v2, exp_q[0].dst, exp_q[0].ill} ||
            (!exp_q[0].ill && {opcode, func} !== {exp_q[0].op, exp_q[0].fn})) begin errors++;
          $display("FAIL rand_data[%0d] got v1=%h v2=%h op=%0d fn=%0d dst=%0d ill=%0b want %h/%h/%0d/%0d/%0d/%0b", i,
                   value1, value2, opcode, func, out_dest, out_illegal, exp_q[0].v1, exp_q[0].v2, exp_q[0].op, exp_q[0].fn, exp_q[0].dst, exp_q[0].ill); end
      end
    end
    ex_wr = 0;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 70000 && exp_cnt != 65535; i++)
      drive(1, mk_r(1, 2, 3, 32), 32'd1, 32'd1, 0, 1);
    checks++; if (issued_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %0d want 65535", issued_count); end
    drive(1, mk_r(1, 2, 3, 32), 32'd1, 32'd1, 0, 1);
    checks++; if (issued_count !== 16'd0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL wrap_zero got cnt=%0d vld=%0b want 0/1", issued_count, out_valid); end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_imm;
    test_illegal;
    test_stall;
    test_flush;
    test_bypass;
    test_random;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 in_valid  in  1  upstream instruction and operands valid.
REQ-004 in_ready  out  1  stage can accept; in_valid&in_ready = accept.
REQ-005 in_instr  in  32  MIPS instruction word.
REQ-006 in_rs_data / in_rt_data  in  32 each  register-file read data for rs, rt.
REQ-007 flush  in  1  discard all held and incoming instructions.
REQ-008 ex_wr, ex_dest[4:0], ex_result[31:0]  in  ALU writeback bypass source.
REQ-009 out_valid  out  1  ALU operands valid; out_ready  in  1  ALU side accepts.
REQ-010 value1, value2  out  32 each  ALU operands; opcode, func  out  6 each  ALU controls.
REQ-011 out_dest  out  5  destination register; out_illegal  out  1  unsupported opcode/func.
REQ-012 issued_count  out  16  instructions delivered (out_valid&out_ready).

Function
REQ-013 Decode: opcode=instr[31:26], func=instr[5:0], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
REQ-014 opcode 0 (R-type): value1=rs data, value2=rt data, func passed, out_dest=rd; legal func = 32,33,36,37,24.
REQ-015 opcode 8, 9: value1=rs data, value2=sign-extended imm, func=0, out_dest=rt.
REQ-016 opcode 12, 13: value1=rs data, value2=zero-extended imm, func=0, out_dest=rt.
REQ-017 Any other opcode, or R-type with illegal func: out_illegal=1, value1=value2=0, out_dest=0; instruction still flows.
REQ-018 Two-entry buffer: main register drives outputs, skid register absorbs one accept while output stalls.
REQ-019 Latency: instruction accepted in cycle N appears on outputs in cycle N+1 when buffer empty.
REQ-020 in_ready = NOT skid-full; registered-state derived, no combinational path from out_ready.
REQ-021 Outputs held stable while out_valid=1 and out_ready=0.
REQ-022 On out_valid&out_ready: skid entry (if any) moves to main next cycle, else main loads new accept or clears out_valid.
REQ-023 Simultaneous accept and deliver with empty skid: new instruction loads main directly, no bubble.
REQ-024 flush: next cycle out_valid=0, skid empty, in_ready=1; an instruction accepted in the flush cycle is dropped; delivery in flush cycle still counts.
REQ-025 issued_count increments by 1 per delivery, wraps 65535->0.
REQ-026 Order preserved; no instruction duplicated or lost except by flush.

Reset
REQ-027 While rst_n=0: out_valid=0, skid empty, value1=value2=0, opcode=func=0, out_dest=0, out_illegal=0, issued_count=0.
REQ-028 in_ready=1 during and immediately after reset.
REQ-029 Reset asserted mid-transfer discards both entries; no delivery counted.

Configuration
REQ-030 Macro OPERAND_BYPASS_EN: when defined, at capture, if ex_wr=1 and ex_dest!=0 and ex_dest==rs, value1=ex_result; same for rt->value2 on R-type only.
REQ-031 OPERAND_BYPASS_EN undefined: ex_wr, ex_dest, ex_result ignored; operands taken only from in_rs_data/in_rt_data.

Verification
REQ-032 R-type add (func 32), rs_data=2, rt_data=3, out_ready=1 -> next cycle value1=2, value2=3, opcode=0, func=32, out_dest=rd.
REQ-033 addi rs_data=2, imm=0xFFFD -> value2=0xFFFFFFFD, func=0; andi imm=0xFFFD -> value2=0x0000FFFD.
REQ-034 out_ready=0, two accepts -> outputs hold first, in_ready=0 after second; out_ready=1 -> both delivered in order, issued_count=2.
REQ-035 flush with full buffer plus accept in same cycle -> next cycle out_valid=0, in_ready=1, issued_count unchanged.
REQ-036 opcode 2 -> out_illegal=1, value1=value2=0; R-type func 42 -> out_illegal=1.
REQ-037 OPERAND_BYPASS_EN defined, ex_wr=1, ex_dest=rs=5, ex_result=7, rs_data=2 -> value1=7; ex_dest=0 -> value1=2; undefined -> value1=2.
